hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory wait freezes.
// A memory wait that outlasts MEM_TIMEOUT cycles locks the pipeline in ERR until reset.
module hazard_ctrl #(
    parameter int unsigned LU_STALL    = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_Rs1,
    input  logic [4:0]  IF_ID_Rs2,
    input  logic [4:0]  ID_EX_Rd,
    input  logic        ID_EX_MemRead,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        Pipe_Freeze,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {StRun, StLstall, StMwait, StErr} state_e;

    state_e      state_q, state_d;
    logic [3:0]  lu_cnt_q, lu_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        ret_q, ret_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_q, stall_d;

    logic hazard;
    logic mwait;
    logic lstall_eff;

    assign hazard = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                    ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
    assign mwait  = mem_req && !mem_ready;
    // Leaving MWAIT resumes whatever the stage was doing when the wait began.
    assign lstall_eff = (state_q == StLstall) || ((state_q == StMwait) && ret_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            lu_cnt_q   <= 4'd0;
            wait_cnt_q <= 8'd0;
            ret_q      <= 1'b0;
            mem_err_q  <= 1'b0;
            stall_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ret_q      <= ret_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = 8'd0;
        ret_d      = 1'b0;
        mem_err_d  = mem_err_q;
        if (state_q == StErr) begin
            wait_cnt_d = wait_cnt_q;
            ret_d      = ret_q;
        end else if (mwait) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            ret_d      = (state_q == StMwait) ? ret_q : (state_q == StLstall);
            if (wait_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                state_d   = StErr;
                mem_err_d = 1'b1;
            end else begin
                state_d = StMwait;
            end
        end else if (branch_taken) begin
            state_d  = StRun;
            lu_cnt_d = 4'd0;
        end else if (lstall_eff) begin
            lu_cnt_d = (lu_cnt_q == 4'd0) ? 4'd0 : lu_cnt_q - 4'd1;
            state_d  = (lu_cnt_q <= 4'd1) ? StRun : StLstall;
        end else if (hazard && (LU_STALL > 1)) begin
            state_d  = StLstall;
            lu_cnt_d = 4'(LU_STALL - 1);
        end else begin
            state_d = StRun;
        end
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;
        if (!rst_n || (state_q == StErr) || mwait) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (branch_taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (lstall_eff || hazard) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    assign stall_d      = (!PC_Write && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; three instances cover LU_STALL of 1, 3 and 2 plus a short timeout.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1, rs2, rd;
    logic       mem_rd, br, req, rdy;

    logic        pcw_a, ifw_a, fl_a, bub_a, frz_a, err_a;
    logic        pcw_b, ifw_b, fl_b, bub_b, frz_b, err_b;
    logic        pcw_c, ifw_c, fl_c, bub_c, frz_c, err_c;
    logic [15:0] sc_a, sc_b, sc_c;
    logic [4:0]  oa, ob, oc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze}
    assign oa = {pcw_a, ifw_a, fl_a, bub_a, frz_a};
    assign ob = {pcw_b, ifw_b, fl_b, bub_b, frz_b};
    assign oc = {pcw_c, ifw_c, fl_c, bub_c, frz_c};

    hazard_ctrl #(.LU_STALL(1), .MEM_TIMEOUT(4)) u_a (
        .clk(clk), .rst_n(rst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .ID_EX_Rd(rd),
        .ID_EX_MemRead(mem_rd), .branch_taken(br), .mem_req(req), .mem_ready(rdy),
        .PC_Write(pcw_a), .IF_ID_Write(ifw_a), .IF_ID_Flush(fl_a), .ID_EX_Bubble(bub_a),
        .Pipe_Freeze(frz_a), .mem_err(err_a), .stall_cycles(sc_a)
    );

    hazard_ctrl #(.LU_STALL(3), .MEM_TIMEOUT(255)) u_b (
        .clk(clk), .rst_n(rst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .ID_EX_Rd(rd),
        .ID_EX_MemRead(mem_rd), .branch_taken(br), .mem_req(req), .mem_ready(rdy),
        .PC_Write(pcw_b), .IF_ID_Write(ifw_b), .IF_ID_Flush(fl_b), .ID_EX_Bubble(bub_b),
        .Pipe_Freeze(frz_b), .mem_err(err_b), .stall_cycles(sc_b)
    );

    hazard_ctrl #(.LU_STALL(2), .MEM_TIMEOUT(255)) u_c (
        .clk(clk), .rst_n(rst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .ID_EX_Rd(rd),
        .ID_EX_MemRead(mem_rd), .branch_taken(br), .mem_req(req), .mem_ready(rdy),
        .PC_Write(pcw_c), .IF_ID_Write(ifw_c), .IF_ID_Flush(fl_c), .ID_EX_Bubble(bub_c),
        .Pipe_Freeze(frz_c), .mem_err(err_c), .stall_cycles(sc_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let the combinational outputs settle.
    task automatic drv(input logic m, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic b, input logic q, input logic y);
        @(negedge clk);
        mem_rd = m; rd = d; rs1 = s1; rs2 = s2; br = b; req = q; rdy = y;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hazard5();
        drv(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mwait4(input logic b);
        drv(1'b0, 5'd3, 5'd1, 5'd2, b, 1'b1, 1'b0);
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        mem_rd = 1'b0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; br = 1'b0; req = 1'b0; rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mem_rd = 1'b0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; br = 1'b0; req = 1'b0; rdy = 1'b0;
        #2;
        check_eq("reset_out_a", 32'(oa), 32'b00001);
        check_eq("reset_out_b", 32'(ob), 32'b00001);
        check_eq("reset_err_a", 32'(err_a), 32'd0);
        check_eq("reset_stall_c", 32'(sc_c), 32'd0);

        // Load-use stall lengths for LU_STALL = 1, 3, 2
        reset_all();
        hazard5();
        check_eq("lu_c1_a", 32'(oa), 32'b00010);
        check_eq("lu_c1_b", 32'(ob), 32'b00010);
        check_eq("lu_c1_c", 32'(oc), 32'b00010);
        idle();
        check_eq("lu_c2_a", 32'(oa), 32'b11000);
        check_eq("lu_c2_b", 32'(ob), 32'b00010);
        check_eq("lu_c2_c", 32'(oc), 32'b00010);
        idle();
        check_eq("lu_c3_b", 32'(ob), 32'b00010);
        check_eq("lu_c3_c", 32'(oc), 32'b11000);
        check_eq("lu_cnt_a", 32'(sc_a), 32'd1);
        idle();
        check_eq("lu_c4_b", 32'(ob), 32'b11000);
        check_eq("lu_cnt_b", 32'(sc_b), 32'd3);
        check_eq("lu_cnt_c", 32'(sc_c), 32'd2);

        // x0 destination never stalls
        drv(1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0);
        check_eq("rd0_a", 32'(oa), 32'b11000);
        check_eq("rd0_b", 32'(ob), 32'b11000);
        idle();
        check_eq("rd0_cnt_a", 32'(sc_a), 32'd1);

        // Taken branch in the second stall cycle cancels the stall
        reset_all();
        hazard5();
        check_eq("br_c1_b", 32'(ob), 32'b00010);
        drv(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        check_eq("br_c2_b", 32'(ob), 32'b11110);
        check_eq("br_c2_a", 32'(oa), 32'b11110);
        idle();
        check_eq("br_c3_b", 32'(ob), 32'b11000);
        check_eq("br_cnt_b", 32'(sc_b), 32'd1);

        // Memory wait inside a load-use stall (LU_STALL = 2)
        reset_all();
        hazard5();
        check_eq("mw_c1_c", 32'(oc), 32'b00010);
        for (int i = 0; i < 4; i++) begin
            mwait4(1'b0);
            check_eq("mw_frz_c", 32'(oc), 32'b00001);
        end
        idle();
        check_eq("mw_resume_c", 32'(oc), 32'b00010);
        idle();
        check_eq("mw_run_c", 32'(oc), 32'b11000);
        check_eq("mw_cnt_c", 32'(sc_c), 32'd6);
        check_eq("mw_err_c", 32'(err_c), 32'd0);
        drv(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
        check_eq("mem_ready_c", 32'(oc), 32'b11000);
        mwait4(1'b1);
        check_eq("br_vs_mwait_c", 32'(oc), 32'b00001);
        drv(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        check_eq("br_after_mw_c", 32'(oc), 32'b11110);

        // Timeout into ERR (MEM_TIMEOUT = 4), then asynchronous reset
        reset_all();
        for (int i = 0; i < 4; i++) begin
            mwait4(1'b0);
            check_eq("to_frz_a", 32'(oa), 32'b00001);
            check_eq("to_err_pre_a", 32'(err_a), 32'd0);
        end
        drv(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        check_eq("err_frz_a", 32'(oa), 32'b00001);
        check_eq("err_flag_a", 32'(err_a), 32'd1);
        repeat (65600) @(negedge clk);
        check_eq("stall_sat_a", 32'(sc_a), 32'hFFFF);
        check_eq("err_hold_a", 32'(err_a), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_err_a", 32'(err_a), 32'd0);
        check_eq("async_out_a", 32'(oa), 32'b00001);
        check_eq("async_cnt_a", 32'(sc_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check_eq("post_rst_a", 32'(oa), 32'b11000);
        hazard5();
        check_eq("post_rst_lu_a", 32'(oa), 32'b00010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
